// File: rtl/uart_rx.sv
// UART receiver, 8N1 (8E1 with UART_RX_PARITY_EN), mid-bit sampling behind a 2-FF synchroniser; no backpressure.
// Strobes are registered, one cycle wide, about 2 + DIV/2 + 9*DIV cycles after the start edge (+DIV with parity).
module uart_rx #(
  parameter int BAUD = 9600,
  parameter int F    = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err
);
  localparam int DIV = F / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
`ifdef UART_RX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t        state, state_nxt;
  logic          rx_m, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          half_tick, full_tick, stop_smp, par_bad;
  logic          valid_nxt, ferr_nxt, perr_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign half_tick = (cnt == HALF_LAST);
  assign full_tick = (cnt == FULL_LAST);
  assign stop_smp  = (state == S_STOP) && full_tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!rx_s) state_nxt = S_START;
      S_START: if (half_tick) state_nxt = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (full_tick && idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
        state_nxt = S_PARITY;
`else
        state_nxt = S_STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (full_tick) state_nxt = S_STOP;
`endif
      // Leaving at mid-stop lets a start edge right after the stop bit be caught.
      S_STOP:  if (full_tick) state_nxt = rx_s ? S_IDLE : S_BREAK;
      S_BREAK: if (rx_s) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    perr_nxt  = 1'b0;
    if (stop_smp) begin
      if (!rx_s)        ferr_nxt  = 1'b1;
      else if (par_bad) perr_nxt  = 1'b1;
      else              valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      if (state_nxt != state || state == S_IDLE || state == S_BREAK || full_tick)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (state == S_DATA && full_tick) begin
        shift[idx] <= rx_s;
        idx        <= idx + 3'd1;
      end else if (state != S_DATA) begin
        idx <= '0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             par_bit <= 1'b0;
    else if (state == S_PARITY && full_tick) par_bit <= rx_s;
  end
  // Even parity: data bits plus parity bit must XOR to zero.
  assign par_bad = (^shift) ^ par_bit;
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data       <= 8'h00;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      valid      <= valid_nxt;
      frame_err  <= ferr_nxt;
      parity_err <= perr_nxt;
      if (valid_nxt) data <= shift;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized frames for uart_rx, checked against an event-level reference model.
module tb_uart_rx;
  localparam int BAUD = 1000000;
  localparam int F    = 16000000;
  localparam int DIV  = F / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int EXP_LAT = 2 + DIV / 2 + (FRAME_BITS - 1) * DIV;

  logic       clk, rst, rx;
  logic [7:0] data;
  logic       valid, frame_err, parity_err;

  uart_rx #(.BAUD(BAUD), .F(F)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data),
    .valid(valid), .frame_err(frame_err), .parity_err(parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [2:0] kind;   // {valid, frame_err, parity_err}
    logic [7:0] dat;
  } ev_t;

  ev_t        ev_q[$];
  int         ev_cyc[$];
  ev_t        exp_q[$];
  logic [7:0] model_data = 8'h00;
  int         n_assert = 0;
  int         n_fail   = 0;
  int         start_cyc;

  always @(negedge clk) begin
    if (valid || frame_err || parity_err) begin
      ev_q.push_back({valid, frame_err, parity_err, data});
      ev_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  // Reference model: outcome of one frame from its stop bit and parity correctness.
  task automatic model_frame(input logic [7:0] b, input logic stop, input logic flip);
    if (!stop)
      exp_q.push_back({3'b010, model_data});
`ifdef UART_RX_PARITY_EN
    else if (flip)
      exp_q.push_back({3'b001, model_data});
`endif
    else begin
      exp_q.push_back({3'b100, b});
      model_data = b;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic flip);
    model_frame(b, stop, flip);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ flip);
`endif
    drive_bit(stop);
  endtask

  task automatic check_events(input string tag);
    chk({tag, "_count"}, ev_q.size(), exp_q.size());
    for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_kind"}, ev_q[i].kind, exp_q[i].kind);
      chk({tag, "_data"}, ev_q[i].dat, exp_q[i].dat);
    end
    chk({tag, "_hold"}, data, model_data);
    ev_q.delete();
    ev_cyc.delete();
    exp_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data"}, data, 8'h00);
    chk({tag, "_strobes"}, {valid, frame_err, parity_err}, 3'b000);
  endtask

  initial begin
    int lat;
    int first_cyc;
    logic [7:0] b;
    logic stop, flip;

    // 1: reset and quiet idle line
    rst = 1'b0;
    rx  = 1'b1;
    #1;
    chk_reset_outputs("rst_in");
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (500) @(posedge clk);
    #1;
    chk_reset_outputs("idle500");
    check_events("idle500");

    // 2: single frame and its latency
    send_frame(8'h55, 1'b1, 1'b0);
    repeat (2 * DIV) @(posedge clk);
    #1;
    lat = (ev_cyc.size() > 0) ? ev_cyc[0] - start_cyc : -1;
    n_assert++;
    assert (lat >= EXP_LAT - 2 && lat <= EXP_LAT + 2) else begin
      n_fail++;
      $error("FAIL latency: observed %0d cycles expected %0d+/-2", lat, EXP_LAT);
    end
    check_events("f55");

    // 3: back-to-back frames, no idle gap
    send_frame(8'hA5, 1'b1, 1'b0);
    first_cyc = start_cyc;
    send_frame(8'h3C, 1'b1, 1'b0);
    repeat (2 * DIV) @(posedge clk);
    #1;
    chk("b2b_spacing", (ev_cyc.size() == 2) ? ev_cyc[1] - ev_cyc[0] : -1, FRAME_BITS * DIV);
    chk("b2b_first_lat", (ev_cyc.size() > 0) ? ev_cyc[0] - first_cyc : -1, lat);
    check_events("b2b");

    // 4: glitch shorter than half a bit, then a real frame
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (3 * DIV) @(posedge clk);
    #1;
    check_events("glitch");
    send_frame(8'h12, 1'b1, 1'b0);
    repeat (2 * DIV) @(posedge clk);
    #1;
    check_events("f12");

    // 5: framing error with the line held low, then recovery
    send_frame(8'h0F, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (3 * DIV) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (2 * DIV) @(posedge clk);
    #1;
    check_events("ferr");
    send_frame(8'h81, 1'b1, 1'b0);
    repeat (2 * DIV) @(posedge clk);
    #1;
    check_events("after_ferr");

    // 6: reset in the middle of data bit 3 of 0xFF
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    rx = 1'b1;
    repeat (DIV / 2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    model_data = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (DIV) @(posedge clk);
    #1;
    check_events("rst_quiet");
    send_frame(8'h81, 1'b1, 1'b0);
    repeat (2 * DIV) @(posedge clk);
    #1;
    check_events("after_rst");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (2 * DIV) @(posedge clk);
    #1;
    check_events("perr07");
`endif

    // Randomized stream: mostly good frames, some framing/parity errors
    for (int n = 0; n < 16; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      flip = ($urandom_range(0, 4) == 0);
      send_frame(b, stop, flip);
      if (!stop) begin
        drive_bit(1'b0);
        drive_bit(1'b1);
      end
    end
    repeat (2 * DIV) @(posedge clk);
    #1;
    check_events("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
